// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer and its PC register:
// datapath widths, the HALT opcode, the fetch FSM states and an
// opcode extraction helper.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fs_state_t;

  // Opcode lives in the top OPC_W bits of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment, otherwise hold.
// Increment wraps modulo 2**ADDR_W through natural overflow.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC update: load, else increment, else hold.
  // NOTE: sequential state is written with <= so every flop samples
  // pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter and fetch controller for the single-cycle datapath.
// Drives the combinational instruction memory, captures each word into
// the instruction register, and handles start, stall, redirect, HALT
// and resume.
// Optional feature macro: FETCH_SEQ_PERF_EN adds fetch_count and
// bubble_count performance counters.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              resume,
  input  logic [DATA_W-1:0] instr_in,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       bubble_count
`endif
);

  fs_state_t         state;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              pc_inc;
  logic              capture;
  logic              is_halt;

  // A word is captured only in RUN with no redirect and no stall, so a
  // squashed or stalled word can never trigger HALT.
  assign capture    = (state == RUN) && !redirect_en && !stall;
  assign is_halt    = (opcode_of(instr_in) == HALT_OP);
  assign instr_addr = pc;

  // PC control: redirect or resume loads, a non-HALT capture increments.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    pc_load      = 1'b0;
    pc_load_addr = redirect_addr;
    pc_inc       = 1'b0;
    if (state == RUN) begin
      if (redirect_en) begin
        pc_load = 1'b1;
      end else if (capture && !is_halt) begin
        pc_inc = 1'b1;
      end
    end else if (state == HALT && resume) begin
      pc_load      = 1'b1;
      pc_load_addr = RESET_PC;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // Fetch FSM with registered instruction register and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ir_out   <= '0;
      ir_valid <= 1'b0;
      pc_out   <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ir_valid <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (redirect_en) begin
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir_out   <= instr_in;
            pc_out   <= pc;
            ir_valid <= 1'b1;
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          ir_valid <= 1'b0;
          if (resume) begin
            halted <= 1'b0;
            state  <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Saturating fetch and bubble counters, cleared by reset and resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else if (state == HALT && resume) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (capture && fetch_count != CNT_MAX) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (state == RUN && (stall || redirect_en) && bubble_count != CNT_MAX) begin
        bubble_count <= bubble_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized stimulus, all compared against a behavioural fetch model.
// Honours FETCH_SEQ_PERF_EN when the design is built with it.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, redirect_en, resume;
  logic [3:0]  redirect_addr;
  logic [15:0] instr_in;
  logic [3:0]  instr_addr;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic [3:0]  pc_out;
  logic        halted;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] fetch_count, bubble_count;
`endif

  logic [15:0] mem [16];

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode, m_pc, m_ir, m_valid, m_pcout, m_halted, m_fc, m_bc;

  assign instr_in = mem[instr_addr];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .resume        (resume),
    .instr_in      (instr_in),
    .instr_addr    (instr_addr),
    .ir_out        (ir_out),
    .ir_valid      (ir_valid),
    .pc_out        (pc_out),
    .halted        (halted)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .bubble_count  (bubble_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ir = 0; m_valid = 0;
    m_pcout = 0; m_halted = 0; m_fc = 0; m_bc = 0;
  endtask

  // One clock edge of the fetch rules, using the inputs held across the edge.
  task automatic model_step();
    int w;
    case (m_mode)
      0: begin
        m_valid = 0;
        if (start) m_mode = 1;
      end
      1: begin
        if (stall || redirect_en) m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
        if (redirect_en) begin
          m_pc    = int'(redirect_addr);
          m_valid = 0;
        end else if (!stall) begin
          w       = int'(mem[m_pc]);
          m_ir    = w;
          m_pcout = m_pc;
          m_valid = 1;
          m_fc    = (m_fc < 65535) ? m_fc + 1 : 65535;
          if ((w >> 12) == 15) begin
            m_mode   = 2;
            m_halted = 1;
          end else begin
            m_pc = (m_pc + 1) % 16;
          end
        end
      end
      default: begin
        m_valid = 0;
        if (resume) begin
          m_pc = 0; m_halted = 0; m_mode = 1; m_fc = 0; m_bc = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("instr_addr", instr_addr, m_pc);
    check("ir_out", ir_out, m_ir);
    check("ir_valid", ir_valid, m_valid);
    check("pc_out", pc_out, m_pcout);
    check("halted", halted, m_halted);
`ifdef FETCH_SEQ_PERF_EN
    check("fetch_count", fetch_count, m_fc);
    check("bubble_count", bubble_count, m_bc);
`endif
  endtask

  // Advance one edge; outputs are compared on the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    resume = 1'b0; redirect_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[4] = 16'hA00A; mem[5] = 16'hAAAA; mem[8] = 16'h5005;
    mem[9] = 16'h5555; mem[15] = 16'hF000;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Start and straight-line fetch.
    start = 1'b1; tick(); start = 1'b0;
    check("idle_to_run_no_valid", ir_valid, 1'b0);
    ticks(5);
    check("ir_at4", ir_out, 16'hA00A);
    check("pc_out4", pc_out, 4'd4);
    tick();
    check("ir_at5", ir_out, 16'hAAAA);
    ticks(3);
    check("ir_at8", ir_out, 16'h5005);

    // Stall holds IR and PC.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ir", ir_out, 16'h5005);
      check("stall_pcout", pc_out, 4'd8);
    end

    // Redirect wins over stall and squashes.
    redirect_en = 1'b1; redirect_addr = 4'd4;
    tick();
    check("redir_bubble", ir_valid, 1'b0);
    check("redir_pc", instr_addr, 4'd4);
    redirect_en = 1'b0; stall = 1'b0;
    tick();
    check("redir_target", ir_out, 16'hA00A);
    ticks(5);
    check("ir_at9", ir_out, 16'h5555);

    // Run into HALT at 15.
    ticks(6);
    check("halt_ir", ir_out, 16'hF000);
    check("halt_valid", ir_valid, 1'b1);
    check("halted_set", halted, 1'b1);
    tick();
    check("halt_valid_drop", ir_valid, 1'b0);
    stall = 1'b1; redirect_en = 1'b1; redirect_addr = 4'd3;
    tick();
    check("halt_pc_frozen", instr_addr, 4'd15);
    stall = 1'b0; redirect_en = 1'b0;
    mem[15] = 16'h1234;
    resume = 1'b1; tick(); resume = 1'b0;
    check("resume_pc", instr_addr, 4'd0);
    check("resume_halted", halted, 1'b0);

    // Wrap plus performance counting: 20 fetches, 2 stalls, 1 redirect.
    ticks(20);
    check("wrap_pcout", pc_out, 4'd3);
    stall = 1'b1; ticks(2); stall = 1'b0;
    redirect_en = 1'b1; redirect_addr = 4'd0; tick(); redirect_en = 1'b0;
`ifdef FETCH_SEQ_PERF_EN
    check("perf_fetch20", fetch_count, 16'd20);
    check("perf_bubble3", bubble_count, 16'd3);
`endif

    // Asynchronous reset mid-run at PC 6.
    ticks(6);
    check("pre_reset_pc", instr_addr, 4'd6);
    async_reset();
    check("areset_valid", ir_valid, 1'b0);
    check("areset_pc", instr_addr, 4'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("restart_pcout", pc_out, 4'd0);
    check("restart_valid", ir_valid, 1'b1);

    // Randomized phase.
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 15)] = 16'($urandom);
      start         = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      redirect_en   = ($urandom_range(0, 7) == 0);
      redirect_addr = 4'($urandom_range(0, 15));
      resume        = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller for the single-cycle datapath.
- Drives the read address of the 16-entry x 16-bit combinational instruction memory.
- Captures each returned word into an instruction register with a valid flag.
- Handles start, stall, redirect (branch/jump from the datapath), HALT detection and resume. It is the only block that sequences instruction memory.

Parameters:
- ADDR_W, 4, instruction address width (memory depth 2**ADDR_W)
- DATA_W, 16, instruction width
- OPC_W, 4, opcode field width, taken from instr_in[DATA_W-1 -: OPC_W]
- HALT_OP, 4'hF, opcode that stops fetching
- RESET_PC, 0, PC value after reset and after resume

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; leaves IDLE and begins fetching at RESET_PC
- stall  in  1  level; hold PC and IR, no new fetch
- redirect_en  in  1  pulse; datapath branch/jump taken
- redirect_addr  in  ADDR_W  target address for redirect
- resume  in  1  pulse; leaves HALT and restarts at RESET_PC
- instr_in  in  DATA_W  word returned by instruction memory (combinational on instr_addr)
- instr_addr  out  ADDR_W  read address to instruction memory, equal to PC
- ir_out  out  DATA_W  registered instruction
- ir_valid  out  1  ir_out holds a live instruction this cycle
- pc_out  out  ADDR_W  address ir_out was fetched from
- halted  out  1  high while in HALT

Behaviour:
- Reset (async, any time, including mid-fetch or mid-stall) forces:
  - state = IDLE, PC = RESET_PC, ir_out = 0, ir_valid = 0, pc_out = 0, halted = 0.
- instr_addr = PC, combinationally. Memory is combinational, so a fetch completes in one edge.
- IDLE: ir_valid = 0, PC held. On start, go to RUN. The first valid IR appears 1 cycle after the first RUN edge.
- RUN, priority order per edge:
  1. redirect_en: PC <= redirect_addr; ir_valid <= 0, which squashes the wrong-path word at the old PC. This holds even if stall = 1 (redirect wins) and even if instr_in is HALT.
  2. stall: PC, ir_out, pc_out and ir_valid all held.
  3. Otherwise: ir_out <= instr_in, pc_out <= PC, ir_valid <= 1.
     - If the instr_in opcode == HALT_OP: PC held, state -> HALT.
     - Else: PC <= PC + 1, modulo 2**ADDR_W (15 -> 0 wraps silently).
- HALT:
  - halted = 1.
  - The HALT instruction stays in ir_out with ir_valid = 1 for exactly 1 cycle, then ir_valid = 0.
  - PC frozen; stall and redirect_en ignored.
  - On resume: PC <= RESET_PC, halted <= 0, state -> RUN.
- start is ignored outside IDLE; resume is ignored outside HALT.
- Throughput: 1 instruction/cycle when not stalled. Redirect bubble: exactly 1 cycle.
- Opcode HALT_OP is recognised only at the capture edge, never on a squashed or stalled word.

Optional Feature:
- FETCH_SEQ_PERF_EN defined:
  - Adds output fetch_count[15:0]. It increments on every edge where ir_valid is loaded to 1, saturates at 16'hFFFF, and is cleared by rst and by resume.
  - Adds output bubble_count[15:0]. It counts RUN cycles with stall or redirect_en, also saturating.
- Macro undefined: both ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, DATA_W, OPC_W, HALT_OP
  - state enum fs_state_t {IDLE, RUN, HALT}
  - opcode extraction helper
- One natural sub-module: pc_reg, holding the PC with load/increment/hold and the wrap rule.
- The FSM and IR stay in the top.

Test Plan:
- Reset then start, memory word 4 = 16'hA00A, no stall: ir_out/pc_out sequence 0000@0, 0000@1, 0000@2, 0000@3, A00A@4, AAAA@5; ir_valid high from cycle 1.
- stall held 3 cycles at PC = 8: ir_out = 16'h5005 and pc_out = 8 hold, instr_addr stays 8; then resumes with 16'h5555@9.
- redirect_en with redirect_addr = 4 while PC = 9 (stall also high): next cycle ir_valid = 0, PC = 4; following cycle ir_out = 16'hA00A.
- Load word 15 = 16'hF000, run from 12: HALT captured with ir_valid 1 for 1 cycle, halted = 1, PC frozen at 15; resume -> PC = 0, fetch restarts. Separately, with a non-HALT word 15, PC wraps 15 -> 0.
- Assert rst asynchronously mid-RUN at PC = 6 (between edges): outputs clear immediately, state IDLE; start restarts at PC 0.
- FETCH_SEQ_PERF_EN: 20 unstalled fetches plus 2 stalls plus 1 redirect -> fetch_count = 20, bubble_count = 3; resume clears both.
